// File: rtl/lsu_pkg.sv
// Shared types, op codes and decode helpers for the MEM-stage load/store unit.
package lsu_pkg;

  localparam logic [7:0] EXE_ADD_OP = 8'b0010_0000;
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  // Value of the MEM/WB stall bit that lets the stage advance.
  localparam logic NoStop = 1'b0;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} lsu_state_t;

  function automatic logic is_load(input logic [7:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction

  function automatic logic misaligned(input logic [7:0] op, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (op)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: mis = off[0];
      EXE_LW_OP, EXE_SW_OP:             mis = |off;
      default:                          mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Big-endian byte enables: lane 3 (sel[3]) holds the byte at offset 0.
  function automatic logic [3:0] sel_gen(input logic [7:0] op, input logic [1:0] off);
    logic [3:0] sel;
    sel = 4'b0000;
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: sel = 4'b1000 >> off;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: sel = off[1] ? 4'b0011 : 4'b1100;
      EXE_LW_OP, EXE_SW_OP:             sel = 4'b1111;
      default:                          sel = 4'b0000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword from a big-endian bus word and extends it.
module mem_load_align
  import lsu_pkg::*;
(
  input  logic [7:0]  aluop,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[31:24];
    case (addr)
      2'd0:    byte_sel = rdata[31:24];
      2'd1:    byte_sel = rdata[23:16];
      2'd2:    byte_sel = rdata[15:8];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr[1] ? rdata[15:0] : rdata[31:16];
  end

  always_comb begin
    data = rdata;
    case (aluop)
      EXE_LB_OP:  data = {{24{byte_sel[7]}}, byte_sel};
      EXE_LBU_OP: data = {24'b0, byte_sel};
      EXE_LH_OP:  data = {{16{half_sel[15]}}, half_sel};
      EXE_LHU_OP: data = {16'b0, half_sel};
      default:    data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: passes EX results through and runs req/gnt/rvalid bus accesses.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic [4:0]        ex_wd,
  input  logic              ex_wreg,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [DATA_W-1:0] ex_hi,
  input  logic [DATA_W-1:0] ex_lo,
  input  logic              ex_whilo,
  input  logic [7:0]        ex_aluop,
  input  logic [ADDR_W-1:0] ex_mem_addr,
  input  logic [DATA_W-1:0] ex_reg2,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [3:0]        dbus_sel,
  output logic [DATA_W-1:0] dbus_wdata,
  input  logic              dbus_gnt,
  input  logic              dbus_rvalid,
  input  logic [DATA_W-1:0] dbus_rdata,
  output logic [4:0]        mem_wd,
  output logic              mem_wreg,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_hi,
  output logic [DATA_W-1:0] mem_lo,
  output logic              mem_whilo,
  output logic              mem_adel,
  output logic              mem_ades,
  output logic              stallreq
);

  lsu_state_t        state_q, state_d;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] store_data;
  logic              capture;
  logic              op_load, op_store, op_misal;

  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[3:0]};

  assign op_load  = is_load(ex_aluop);
  assign op_store = is_store(ex_aluop);
  assign op_misal = misaligned(ex_aluop, ex_mem_addr[1:0]);

  mem_load_align u_load_align (
    .aluop (ex_aluop),
    .addr  (ex_mem_addr[1:0]),
    .rdata (dbus_rdata),
    .data  (load_data)
  );

  always_comb begin
    store_data = '0;
    case (ex_aluop)
      EXE_SB_OP: store_data = {4{ex_reg2[7:0]}};
      EXE_SH_OP: store_data = {2{ex_reg2[15:0]}};
      EXE_SW_OP: store_data = ex_reg2;
      default:   store_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) rdata_q <= load_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    dbus_req   = 1'b0;
    dbus_we    = op_store;
    dbus_addr  = {ex_mem_addr[ADDR_W-1:2], 2'b00};
    dbus_sel   = sel_gen(ex_aluop, ex_mem_addr[1:0]);
    dbus_wdata = store_data;
    stallreq   = 1'b0;
    mem_wd     = ex_wd;
    mem_wreg   = ex_wreg;
    mem_wdata  = ex_wdata;
    mem_hi     = ex_hi;
    mem_lo     = ex_lo;
    mem_whilo  = ex_whilo;
    mem_adel   = 1'b0;
    mem_ades   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (op_load || op_store) begin
          if (op_misal) begin
            mem_adel  = op_load;
            mem_ades  = op_store;
            mem_wreg  = 1'b0;
            mem_whilo = 1'b0;
          end else begin
            // Request stays asserted with stable attributes until granted.
            dbus_req = 1'b1;
            stallreq = 1'b1;
            if (dbus_gnt) state_d = WAIT;
          end
        end
      end
      WAIT: begin
        stallreq = 1'b1;
        if (dbus_rvalid) begin
          capture = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (op_load) mem_wdata = rdata_q;
        if (op_store) mem_wreg = 1'b0;
        if (stall[4] == NoStop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      capture   = 1'b0;
      dbus_req  = 1'b0;
      stallreq  = 1'b0;
      mem_wd    = '0;
      mem_wreg  = 1'b0;
      mem_wdata = '0;
      mem_hi    = '0;
      mem_lo    = '0;
      mem_whilo = 1'b0;
      mem_adel  = 1'b0;
      mem_ades  = 1'b0;
    end
  end

endmodule
